qpp_interleaver_pingpong: RTL and testbench
===========================================

// Module: qpp_interleaver_pingpong
// PURPOSE
// Second-generation turbo-code interleaver. Accepts a code block byte-serially into an
// internal ping-pong bit buffer. Streams it bit-serially in natural order (outi) and in
// QPP order pi(i)=(F1*i+F2*i^2) mod K (outpii). Sits between code-block segmentation and
// the two constituent encoders. One block can be written while the other bank is read.
// PARAMETERS
// KMAX=6144     bank depth in bits; max block size
// K0=1056       block size when k_size_6144=0 (multiple of 8)
// K0_F1=17      QPP f1 for K0
// K0_F2=66      QPP f2 for K0
// K1=6144       block size when k_size_6144=1 (multiple of 8)
// K1_F1=263     QPP f1 for K1
// K1_F2=480     QPP f2 for K1
// AW=13         index width, $clog2(KMAX)
// PORTS
// clock            in   1   single clock, rising edge
// rst              in   1   asynchronous, active-high reset
// k_size_6144      in   1   block size select; sampled with first byte of each block
// in_valid         in   1   in_byte valid
// in_byte          in   8   data; bit 7 = lowest bit index c(8n)
// in_ready         out  1   buffer can accept a byte this cycle
// out_ready        in   1   downstream accepts a bit pair this cycle
// out_valid        out  1   outi/outpii valid
// outi             out  1   c(i)
// outpii           out  1   c(pi(i))
// out_start        out  1   high with bit i=0 of a block
// process_complete out  1   high with bit i=K-1 of a block
// BEHAVIOUR
// - Reset: both banks empty; wr_bank=rd_bank=0; all indices 0; in_ready=1; out_valid,
//   outi, outpii, out_start, process_complete=0. Bank bit contents not cleared.
// - Write: byte accepted when in_valid&&in_ready. First byte latches K into the bank tag.
//   Byte n fills bits 8n..8n+7. After byte K/8-1 the bank is marked full and wr_bank
//   toggles. in_ready=0 while bank wr_bank is full. in_valid with in_ready=0 is ignored.
// - Read FSM: IDLE -> RUN when bank rd_bank is full. RUN steps i=0..K-1, one step per
//   cycle with out_ready=1. It holds every register when out_ready=0. After i=K-1 it
//   clears the bank's full flag, toggles rd_bank, and returns to IDLE, or stays in RUN
//   if the other bank is already full (zero-gap back-to-back).
// - QPP recursion, no multipliers: pi(0)=0, g(0)=(F1+F2) mod K;
//   pi(i+1)=(pi(i)+g(i)) mod K; g(i+1)=(g(i)+2F2) mod K.
//   Every mod is one conditional subtract, since both operands are <K. (2F2 mod K) is a
//   per-size constant. Widths AW bits, plus one carry bit.
// - Output registered: bit pair for index i appears 1 cycle after i is issued. out_valid
//   stays high across a stall; data is held stable until accepted.
// - Full-flag set (write end) and clear (read end) on different banks in one cycle:
//   both take effect. Bank flags never conflict, by construction.
// - k_size_6144 change mid-block: no effect until the next block's first byte.
// - rst mid-operation: everything aborts immediately to reset state; partial block is lost.
// CONFIGURATION
// INTERLEAVER_BYPASS_EN defined: adds input port bypass (1 bit, sampled at IDLE->RUN).
//   With bypass=1 for a block, outpii=outi (pi(i)=i); timing unchanged.
// Not defined: no bypass port; outpii is always QPP-permuted.
// TESTING
// 1 K=1056, bytes 0x80,0x00.. (only c(0)=1): outi=1 at i=0 only; outpii=1 at i=0 only;
//   pi(1)=83, pi(2)=298 (probe); process_complete at bit 1055.
// 2 K=6144, random data: outpii(i)==c(pi(i)) for all i vs model; pi(1)=743, pi(2)=2446.
// 3 Two K=1056 blocks written back-to-back: in_ready drops only when both banks are full;
//   second block's out_start follows first block's process_complete with 0 idle cycles.
// 4 out_ready toggled pseudo-randomly: accepted stream equals the no-stall stream bit-exact.
// 5 rst asserted at bit 500 of read and byte 40 of write: outputs 0 next edge; a fresh
//   block afterwards starts at i=0 and is correct.
// 6 INTERLEAVER_BYPASS_EN, bypass=1, K=1056: outpii==outi for all 1056 bits.

Source files
------------

// File: rtl/qpp_interleaver_pingpong.sv
// Ping-pong bit buffer for the turbo encoder: byte-serial fill, bit-serial readout in natural and QPP order.
// Defining INTERLEAVER_BYPASS_EN adds a per-block bypass input that forces pi(i)=i.
module qpp_interleaver_pingpong #(
  parameter int KMAX  = 6144,
  parameter int K0    = 1056,
  parameter int K0_F1 = 17,
  parameter int K0_F2 = 66,
  parameter int K1    = 6144,
  parameter int K1_F1 = 263,
  parameter int K1_F2 = 480,
  parameter int AW    = 13
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       k_size_6144,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  input  logic       out_ready,
`ifdef INTERLEAVER_BYPASS_EN
  input  logic       bypass,
`endif
  output logic       out_valid,
  output logic       outi,
  output logic       outpii,
  output logic       out_start,
  output logic       process_complete
);

  localparam int NBYTE = KMAX / 8;
  localparam int BW    = AW - 3;

  localparam logic [AW:0] KL0 = (AW+1)'(K0);
  localparam logic [AW:0] KL1 = (AW+1)'(K1);
  localparam logic [AW:0] G00 = (AW+1)'((K0_F1 + K0_F2) % K0);
  localparam logic [AW:0] G01 = (AW+1)'((K1_F1 + K1_F2) % K1);
  localparam logic [AW:0] D0  = (AW+1)'((2 * K0_F2) % K0);
  localparam logic [AW:0] D1  = (AW+1)'((2 * K1_F2) % K1);
  localparam logic [BW-1:0] LB0 = BW'(K0 / 8 - 1);
  localparam logic [BW-1:0] LB1 = BW'(K1 / 8 - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [7:0]    mem [0:1][0:NBYTE-1];
  logic [1:0]    bank_full;
  logic [1:0]    bank_sel;
  logic          wr_bank;
  logic          rd_bank;
  logic [BW-1:0] wr_cnt;

  logic [0:0]    state;
  logic [AW-1:0] idx;
  logic [AW-1:0] pi_q;
  logic [AW:0]   g_q;
  logic          byp_q;

  // ---------------- write side ----------------
  logic wr_fire;
  logic wr_sel;
  logic wr_last;

  assign in_ready = ~bank_full[wr_bank];
  assign wr_fire  = in_valid & in_ready;
  // The size tag is latched with byte 0, so byte 0 must decide with the live input.
  assign wr_sel   = (wr_cnt == '0) ? k_size_6144 : bank_sel[wr_bank];
  assign wr_last  = (wr_cnt == (wr_sel ? LB1 : LB0));

  always_ff @(posedge clock) begin
    if (wr_fire) mem[wr_bank][wr_cnt] <= in_byte;
  end

  // ---------------- read datapath ----------------
  logic          rd_sel;
  logic          nx_sel;
  logic [AW:0]   k_cur;
  logic [AW:0]   d_cur;
  logic [AW:0]   pi_sum;
  logic [AW:0]   g_sum;
  logic [AW-1:0] pi_nxt;
  logic [AW:0]   g_nxt;
  logic          last;
  logic          rd_done;
  logic [AW-1:0] p_addr;
  logic [7:0]    byte_i;
  logic [7:0]    byte_p;
  logic          bit_i;
  logic          bit_p;

  assign rd_sel = bank_sel[rd_bank];
  assign nx_sel = bank_sel[~rd_bank];
  assign k_cur  = rd_sel ? KL1 : KL0;
  assign d_cur  = rd_sel ? D1 : D0;

  always_comb begin
    pi_sum = {1'b0, pi_q} + g_q;
    g_sum  = g_q + d_cur;
    pi_nxt = (pi_sum >= k_cur) ? AW'(pi_sum - k_cur) : AW'(pi_sum);
    g_nxt  = (g_sum >= k_cur) ? (g_sum - k_cur) : g_sum;
  end

  assign last    = ({1'b0, idx} == (k_cur - 1'b1));
  assign rd_done = (state == S_RUN) && out_ready && last;
  assign p_addr  = byp_q ? idx : pi_q;
  assign byte_i  = mem[rd_bank][idx[3 +: BW]];
  assign byte_p  = mem[rd_bank][p_addr[3 +: BW]];
  assign bit_i   = byte_i[3'd7 - idx[2:0]];
  assign bit_p   = byte_p[3'd7 - p_addr[2:0]];

  logic byp_in;
`ifdef INTERLEAVER_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  // ---------------- bank bookkeeping ----------------
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      bank_full <= '0;
      bank_sel  <= '0;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) bank_sel[wr_bank] <= k_size_6144;
        if (wr_last) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
          wr_cnt             <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      // Reader and writer always own different banks, so set and clear never collide.
      if (rd_done) bank_full[rd_bank] <= 1'b0;
    end
  end

  // ---------------- read FSM and output register ----------------
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      rd_bank          <= 1'b0;
      idx              <= '0;
      pi_q             <= '0;
      g_q              <= '0;
      byp_q            <= 1'b0;
      out_valid        <= 1'b0;
      outi             <= 1'b0;
      outpii           <= 1'b0;
      out_start        <= 1'b0;
      process_complete <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (out_ready) begin
            out_valid        <= 1'b0;
            out_start        <= 1'b0;
            process_complete <= 1'b0;
          end
          if (bank_full[rd_bank]) begin
            state <= S_RUN;
            idx   <= '0;
            pi_q  <= '0;
            g_q   <= rd_sel ? G01 : G00;
            byp_q <= byp_in;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid        <= 1'b1;
            outi             <= bit_i;
            outpii           <= bit_p;
            out_start        <= (idx == '0);
            process_complete <= last;
            if (last) begin
              rd_bank <= ~rd_bank;
              idx     <= '0;
              pi_q    <= '0;
              g_q     <= nx_sel ? G01 : G00;
              byp_q   <= byp_in;
              if (!bank_full[~rd_bank]) state <= S_IDLE;
            end else begin
              idx  <= idx + 1'b1;
              pi_q <= pi_nxt;
              g_q  <= g_nxt;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qpp_interleaver_pingpong.sv
// Directed bench for qpp_interleaver_pingpong; QPP order is checked against the closed-form pi(i).
module tb_qpp_interleaver_pingpong;

  logic       clock = 1'b0;
  logic       rst;
  logic       k_size_6144;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic       outi;
  logic       outpii;
  logic       out_start;
  logic       process_complete;
`ifdef INTERLEAVER_BYPASS_EN
  logic       bypass;
`endif

  int total = 0;
  int bad   = 0;
  int hold_err;

  logic [7:0] blk [0:1][0:767];
  logic       obs_i [0:12287];
  logic       obs_p [0:12287];
  logic       obs_s [0:12287];
  logic       obs_c [0:12287];
  int         obs_cyc [0:12287];

  always #5 clock = ~clock;

  qpp_interleaver_pingpong #(
    .KMAX(6144), .K0(1056), .K0_F1(17), .K0_F2(66),
    .K1(6144), .K1_F1(263), .K1_F2(480), .AW(13)
  ) dut (
    .clock(clock),
    .rst(rst),
    .k_size_6144(k_size_6144),
    .in_valid(in_valid),
    .in_byte(in_byte),
    .in_ready(in_ready),
    .out_ready(out_ready),
`ifdef INTERLEAVER_BYPASS_EN
    .bypass(bypass),
`endif
    .out_valid(out_valid),
    .outi(outi),
    .outpii(outpii),
    .out_start(out_start),
    .process_complete(process_complete)
  );

  function automatic logic cbit(int b, int i);
    logic [7:0] v;
    v = blk[b][i / 8];
    return v[7 - (i % 8)];
  endfunction

  function automatic int pi_of(int k, int i);
    longint f1, f2, li;
    li = i;
    if (k == 1056) begin f1 = 17; f2 = 66; end
    else begin f1 = 263; f2 = 480; end
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  // First index where the captured stream departs from the data model, or -1.
  function automatic int first_bad(int b, int k, int base, bit perm);
    logic e, o;
    for (int i = 0; i < k; i++) begin
      e = perm ? cbit(b, pi_of(k, i)) : cbit(b, i);
      o = perm ? obs_p[base + i] : obs_i[base + i];
      if (o !== e) return i;
    end
    return -1;
  endfunction

  task automatic fill_rand(input int b);
    for (int j = 0; j < 768; j++) blk[b][j] = 8'($urandom);
  endtask

  task automatic write_block(input int b, input bit ksel, input bit flip, input int nb, input bit chain);
    int n = 0;
    int waits = 0;
    logic acc;
    while (n < nb && waits < 20000) begin
      @(negedge clock);
      in_valid    = 1'b1;
      in_byte     = blk[b][n];
      k_size_6144 = (flip && n > 0) ? ~ksel : ksel;
      acc = in_ready;
      @(posedge clock);
      if (acc) n++; else waits++;
    end
    if (!chain) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
    total++;
    if (n !== nb) begin
      bad++;
      $display("FAIL write_accept: accepted=%0d required=%0d", n, nb);
    end
  endtask

  task automatic collect(input int nbits, input bit stall);
    int cnt = 0;
    int cyc = 0;
    logic hold = 1'b0;
    logic hi = 1'b0;
    logic hp = 1'b0;
    while (cnt < nbits && cyc < 30000) begin
      @(negedge clock);
      if (hold && (out_valid !== 1'b1 || outi !== hi || outpii !== hp)) hold_err++;
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        obs_i[cnt] = outi; obs_p[cnt] = outpii;
        obs_s[cnt] = out_start; obs_c[cnt] = process_complete;
        obs_cyc[cnt] = cyc;
        cnt++;
      end
      hold = out_valid && !out_ready;
      hi = outi; hp = outpii;
      cyc++;
    end
    @(negedge clock);
    out_ready = 1'b0;
    total++;
    if (cnt !== nbits) begin
      bad++;
      $display("FAIL collect_count: got=%0d required=%0d", cnt, nbits);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if ({in_ready, out_valid, outi, outpii, out_start, process_complete} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_state: got=%b required=100000",
               {in_ready, out_valid, outi, outpii, out_start, process_complete});
    end
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_k1056();
    int r, ns, nc;
    for (int j = 0; j < 768; j++) blk[0][j] = 8'h00;
    blk[0][0] = 8'h80;
    write_block(0, 1'b0, 1'b1, 132, 1'b0);
    collect(1056, 1'b0);
    r = first_bad(0, 1056, 0, 1'b0);
    total++;
    if (r !== -1) begin bad++; $display("FAIL k1056_outi: idx=%0d got=%b required=%b", r, obs_i[r], cbit(0, r)); end
    r = first_bad(0, 1056, 0, 1'b1);
    total++;
    if (r !== -1) begin bad++; $display("FAIL k1056_outpii: idx=%0d got=%b", r, obs_p[r]); end
    total++;
    if (obs_i[0] !== 1'b1 || obs_p[0] !== 1'b1) begin
      bad++; $display("FAIL k1056_bit0: outi=%b outpii=%b required=1 1", obs_i[0], obs_p[0]);
    end
    ns = 0; nc = 0;
    for (int i = 0; i < 1056; i++) begin ns += int'(obs_s[i]); nc += int'(obs_c[i]); end
    total++;
    if (obs_s[0] !== 1'b1 || ns !== 1) begin bad++; $display("FAIL k1056_start: at0=%b count=%0d required=1 1", obs_s[0], ns); end
    total++;
    if (obs_c[1055] !== 1'b1 || nc !== 1) begin bad++; $display("FAIL k1056_complete: at1055=%b count=%0d required=1 1", obs_c[1055], nc); end

    // Probe pi(1)=83 and pi(2)=298: only those two source bits set.
    for (int j = 0; j < 768; j++) blk[0][j] = 8'h00;
    blk[0][10] = 8'h10;
    blk[0][37] = 8'h20;
    write_block(0, 1'b0, 1'b0, 132, 1'b0);
    collect(1056, 1'b0);
    total++;
    if ({obs_p[0], obs_p[1], obs_p[2], obs_p[3]} !== 4'b0110) begin
      bad++; $display("FAIL k1056_probe: outpii[0..3]=%b required=0110", {obs_p[0], obs_p[1], obs_p[2], obs_p[3]});
    end
    r = first_bad(0, 1056, 0, 1'b1);
    total++;
    if (r !== -1) begin bad++; $display("FAIL k1056_probe_stream: idx=%0d got=%b", r, obs_p[r]); end
  endtask

  task automatic test_k6144_random();
    int r;
    fill_rand(0);
    write_block(0, 1'b1, 1'b0, 768, 1'b0);
    collect(6144, 1'b0);
    r = first_bad(0, 6144, 0, 1'b0);
    total++;
    if (r !== -1) begin bad++; $display("FAIL k6144_outi: idx=%0d got=%b", r, obs_i[r]); end
    r = first_bad(0, 6144, 0, 1'b1);
    total++;
    if (r !== -1) begin bad++; $display("FAIL k6144_outpii: idx=%0d got=%b", r, obs_p[r]); end
    total++;
    if (obs_p[1] !== cbit(0, 743) || obs_p[2] !== cbit(0, 2446)) begin
      bad++; $display("FAIL k6144_probe: got=%b%b required=%b%b", obs_p[1], obs_p[2], cbit(0, 743), cbit(0, 2446));
    end
    total++;
    if (obs_s[0] !== 1'b1 || obs_c[6143] !== 1'b1 || obs_c[6142] !== 1'b0) begin
      bad++; $display("FAIL k6144_frame: start0=%b c6142=%b c6143=%b required=1 0 1", obs_s[0], obs_c[6142], obs_c[6143]);
    end
  endtask

  task automatic test_back_to_back();
    logic rdy1, rdy2;
    fill_rand(0);
    fill_rand(1);
    write_block(0, 1'b0, 1'b0, 132, 1'b1);
    #1 rdy1 = in_ready;
    write_block(1, 1'b0, 1'b0, 132, 1'b0);
    rdy2 = in_ready;
    total++;
    if ({rdy1, rdy2} !== 2'b10) begin bad++; $display("FAIL b2b_in_ready: got=%b%b required=10", rdy1, rdy2); end
    collect(2112, 1'b0);
    total++;
    if (first_bad(0, 1056, 0, 1'b1) !== -1 || first_bad(1, 1056, 1056, 1'b1) !== -1 ||
        first_bad(0, 1056, 0, 1'b0) !== -1 || first_bad(1, 1056, 1056, 1'b0) !== -1) begin
      bad++; $display("FAIL b2b_data: got=%0d %0d required=-1 -1",
                      first_bad(0, 1056, 0, 1'b1), first_bad(1, 1056, 1056, 1'b1));
    end
    total++;
    if (obs_c[1055] !== 1'b1 || obs_s[1056] !== 1'b1 || (obs_cyc[1056] - obs_cyc[1055]) !== 1) begin
      bad++; $display("FAIL b2b_gap: complete=%b start=%b gap=%0d required=1 1 1",
                      obs_c[1055], obs_s[1056], obs_cyc[1056] - obs_cyc[1055]);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain_ready: got=%b required=1", in_ready); end
  endtask

  task automatic test_stall();
    int r;
    fill_rand(0);
    hold_err = 0;
    write_block(0, 1'b0, 1'b0, 132, 1'b0);
    collect(1056, 1'b1);
    r = first_bad(0, 1056, 0, 1'b1);
    total++;
    if (r !== -1 || first_bad(0, 1056, 0, 1'b0) !== -1) begin
      bad++; $display("FAIL stall_stream: idx=%0d required=-1", r);
    end
    total++;
    if (hold_err !== 0) begin bad++; $display("FAIL stall_hold: violations=%0d required=0", hold_err); end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    int n = 0;
    int cyc = 0;
    logic acc = 1'b0;
    int r;
    fill_rand(0);
    fill_rand(1);
    write_block(0, 1'b0, 1'b0, 132, 1'b0);
    while (cnt < 500 && cyc < 5000) begin
      @(negedge clock);
      if (acc) n++;
      out_ready = 1'b1;
      if (cnt >= 460 && n < 132) begin
        in_valid = 1'b1; in_byte = blk[1][n]; k_size_6144 = 1'b0; acc = in_ready;
      end else begin
        in_valid = 1'b0; acc = 1'b0;
      end
      if (out_valid) cnt++;
      cyc++;
    end
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, outi, outpii, out_start, process_complete} !== 6'b100000 || cnt !== 500) begin
      bad++; $display("FAIL midrst_state: got=%b bits=%0d required=100000 500",
                      {in_ready, out_valid, outi, outpii, out_start, process_complete}, cnt);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
    fill_rand(0);
    write_block(0, 1'b0, 1'b0, 132, 1'b0);
    collect(1056, 1'b0);
    r = first_bad(0, 1056, 0, 1'b1);
    total++;
    if (obs_s[0] !== 1'b1 || r !== -1 || first_bad(0, 1056, 0, 1'b0) !== -1) begin
      bad++; $display("FAIL midrst_fresh: start=%b idx=%0d required=1 -1", obs_s[0], r);
    end
  endtask

`ifdef INTERLEAVER_BYPASS_EN
  task automatic test_bypass();
    int r = -1;
    fill_rand(0);
    bypass = 1'b1;
    write_block(0, 1'b0, 1'b0, 132, 1'b0);
    collect(1056, 1'b0);
    bypass = 1'b0;
    for (int i = 1055; i >= 0; i--) if (obs_p[i] !== cbit(0, i) || obs_p[i] !== obs_i[i]) r = i;
    total++;
    if (r !== -1) begin bad++; $display("FAIL bypass_stream: idx=%0d outpii=%b outi=%b", r, obs_p[r], obs_i[r]); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    k_size_6144 = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    out_ready = 1'b0;
    hold_err = 0;
`ifdef INTERLEAVER_BYPASS_EN
    bypass = 1'b0;
`endif
    test_reset();
    test_single_k1056();
    test_k6144_random();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef INTERLEAVER_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
